// File: rtl/multichannel_pool_unit.sv
// Multichannel max pooling over a time-multiplexed convolution stream, using one shared partial-window store.
// Optional average mode is enabled by defining POOL_AVG_EN, which adds the pool_mode port.
module multichannel_pool_unit #(
  parameter int BitSize            = 8,
  parameter int ImageWidth         = 16,
  parameter int ImageHeight        = 16,
  parameter int NumberOfK          = 8,
  parameter int ProcessingElements = 2,
  parameter int PoolN              = 2,
  parameter int Signed             = 1,
  localparam int CyclesPerPixel    = NumberOfK / ProcessingElements,
  localparam int WinCols           = ImageWidth / PoolN,
  localparam int WinRows           = ImageHeight / PoolN,
  localparam int GW = (CyclesPerPixel > 1) ? $clog2(CyclesPerPixel) : 1,
  localparam int CW = (WinCols > 1) ? $clog2(WinCols) : 1,
  localparam int RW = (WinRows > 1) ? $clog2(WinRows) : 1
) (
  input  logic                                         clk,
  input  logic                                         res_n,
  input  logic                                         in_valid,
  input  logic                                         in_sof,
  input  logic [ProcessingElements-1:0][BitSize-1:0]   in_data,
`ifdef POOL_AVG_EN
  input  logic                                         pool_mode,
`endif
  output logic                                         out_valid,
  output logic [GW-1:0]                                out_group,
  output logic [CW-1:0]                                out_col,
  output logic [RW-1:0]                                out_row,
  output logic [ProcessingElements-1:0][BitSize-1:0]   out_data,
  output logic                                         frame_done,
  output logic                                         sync_err
);

  localparam int PW = (PoolN > 1) ? $clog2(PoolN) : 1;
`ifdef POOL_AVG_EN
  localparam int LogN = $clog2(PoolN);
  localparam int Shift = 2 * LogN;
  localparam int AccW = BitSize + 2 * LogN;
`else
  localparam int AccW = BitSize;
`endif

  localparam logic [GW-1:0] BEAT_LAST = GW'(CyclesPerPixel - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(PoolN - 1);
  localparam logic [CW-1:0] WC_LAST   = CW'(WinCols - 1);
  localparam logic [RW-1:0] WR_LAST   = RW'(WinRows - 1);

  // Position is kept as window index plus phase inside the window, which avoids dividers.
  logic [GW-1:0] beat_q, beat_e, beat_n;
  logic [PW-1:0] cph_q, cph_e, cph_n;
  logic [PW-1:0] rph_q, rph_e, rph_n;
  logic [CW-1:0] wc_q, wc_e, wc_n;
  logic [RW-1:0] wr_q, wr_e, wr_n;
  logic          sof_hit, at_origin, win_first, win_last, frame_last;

  logic [AccW-1:0]    pm [WinCols][CyclesPerPixel][ProcessingElements];
  logic [AccW-1:0]    acc_n [ProcessingElements];
  logic [BitSize-1:0] res   [ProcessingElements];
  logic [AccW-1:0]    cur;

  function automatic logic [BitSize-1:0] max_of(input logic [BitSize-1:0] a,
                                                 input logic [BitSize-1:0] b);
    if (Signed != 0) return ($signed(a) > $signed(b)) ? a : b;
    else             return (a > b) ? a : b;
  endfunction

`ifdef POOL_AVG_EN
  logic mode_q, mode_avg;

  function automatic logic [AccW-1:0] ext(input logic [BitSize-1:0] v);
    if (Signed != 0) return AccW'($signed(v));
    else             return AccW'(v);
  endfunction

  function automatic logic [BitSize-1:0] avg_of(input logic [AccW-1:0] a);
    logic [AccW-1:0] s;
    if (Signed != 0) s = $signed(a) >>> Shift;
    else             s = a >> Shift;
    return s[BitSize-1:0];
  endfunction
`endif

  always_comb begin
    sof_hit   = in_valid & in_sof;
    at_origin = (beat_q == '0) && (cph_q == '0) && (wc_q == '0) &&
                (rph_q == '0) && (wr_q == '0);
    beat_e = sof_hit ? '0 : beat_q;
    cph_e  = sof_hit ? '0 : cph_q;
    wc_e   = sof_hit ? '0 : wc_q;
    rph_e  = sof_hit ? '0 : rph_q;
    wr_e   = sof_hit ? '0 : wr_q;
    win_first  = (rph_e == '0) && (cph_e == '0);
    win_last   = (rph_e == PH_LAST) && (cph_e == PH_LAST);
    frame_last = win_last && (beat_e == BEAT_LAST) && (wc_e == WC_LAST) && (wr_e == WR_LAST);
  end

  always_comb begin
    beat_n = beat_e + GW'(1);
    cph_n  = cph_e;
    wc_n   = wc_e;
    rph_n  = rph_e;
    wr_n   = wr_e;
    if (beat_e == BEAT_LAST) begin
      beat_n = '0;
      if (cph_e == PH_LAST) begin
        cph_n = '0;
        if (wc_e == WC_LAST) begin
          wc_n = '0;
          if (rph_e == PH_LAST) begin
            rph_n = '0;
            wr_n  = (wr_e == WR_LAST) ? '0 : wr_e + RW'(1);
          end else begin
            rph_n = rph_e + PW'(1);
          end
        end else begin
          wc_n = wc_e + CW'(1);
        end
      end else begin
        cph_n = cph_e + PW'(1);
      end
    end
  end

`ifdef POOL_AVG_EN
  // The mode latched at the first beat of the frame governs the whole frame, including that beat.
  assign mode_avg = (sof_hit || at_origin) ? pool_mode : mode_q;
`endif

  always_comb begin
    cur = '0;
    for (int p = 0; p < ProcessingElements; p++) begin
      acc_n[p] = '0;
      res[p]   = '0;
      cur      = pm[wc_e][beat_e][p];
`ifdef POOL_AVG_EN
      if (mode_avg) begin
        acc_n[p] = win_first ? ext(in_data[p]) : cur + ext(in_data[p]);
        res[p]   = avg_of(acc_n[p]);
      end else begin
        res[p]   = win_first ? in_data[p] : max_of(cur[BitSize-1:0], in_data[p]);
        acc_n[p] = AccW'(res[p]);
      end
`else
      res[p]   = win_first ? in_data[p] : max_of(cur, in_data[p]);
      acc_n[p] = res[p];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n && in_valid) begin
      for (int p = 0; p < ProcessingElements; p++)
        pm[wc_e][beat_e][p] <= acc_n[p];
    end
  end

  always_ff @(posedge clk) begin
    if (res_n) begin
      beat_q     <= '0;
      cph_q      <= '0;
      wc_q       <= '0;
      rph_q      <= '0;
      wr_q       <= '0;
      out_valid  <= 1'b0;
      out_group  <= '0;
      out_col    <= '0;
      out_row    <= '0;
      out_data   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
`ifdef POOL_AVG_EN
      mode_q     <= 1'b0;
`endif
    end else begin
      out_valid  <= in_valid && win_last;
      frame_done <= in_valid && frame_last;
      if (in_valid) begin
        beat_q <= beat_n;
        cph_q  <= cph_n;
        wc_q   <= wc_n;
        rph_q  <= rph_n;
        wr_q   <= wr_n;
        if (win_last) begin
          out_group <= beat_e;
          out_col   <= wc_e;
          out_row   <= wr_e;
          for (int p = 0; p < ProcessingElements; p++)
            out_data[p] <= res[p];
        end
        if (sof_hit && !at_origin)
          sync_err <= 1'b1;
`ifdef POOL_AVG_EN
        if (sof_hit || at_origin)
          mode_q <= pool_mode;
`endif
      end
    end
  end

endmodule

// File: tb/tb_multichannel_pool_unit.sv
// Scoreboard bench for multichannel_pool_unit: an unsigned default-geometry instance plus a tiny signed instance.
module tb_multichannel_pool_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            res_n, in_valid, in_sof, pool_mode;
  logic [1:0][7:0] in_data;
  logic            out_valid, frame_done, sync_err;
  logic [1:0]      out_group;
  logic [2:0]      out_col, out_row;
  logic [1:0][7:0] out_data;

  logic            s_res_n, s_valid, s_sof, s_pool_mode;
  logic [1:0][7:0] s_data;
  logic            s_out_valid, s_frame_done, s_sync_err;
  logic [0:0]      s_out_group, s_out_col, s_out_row;
  logic [1:0][7:0] s_out_data;

  multichannel_pool_unit #(.Signed(0)) dut (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
`ifdef POOL_AVG_EN
    .pool_mode(pool_mode),
`endif
    .out_valid(out_valid), .out_group(out_group), .out_col(out_col), .out_row(out_row),
    .out_data(out_data), .frame_done(frame_done), .sync_err(sync_err)
  );

  multichannel_pool_unit #(.ImageWidth(2), .ImageHeight(2), .NumberOfK(2),
                           .ProcessingElements(2), .PoolN(2), .Signed(1)) dut_s (
    .clk(clk), .res_n(s_res_n), .in_valid(s_valid), .in_sof(s_sof), .in_data(s_data),
`ifdef POOL_AVG_EN
    .pool_mode(s_pool_mode),
`endif
    .out_valid(s_out_valid), .out_group(s_out_group), .out_col(s_out_col), .out_row(s_out_row),
    .out_data(s_out_data), .frame_done(s_frame_done), .sync_err(s_sync_err)
  );

  typedef struct {
    bit          valid;
    bit          zero;
    logic [1:0]  grp;
    logic [2:0]  col;
    logic [2:0]  row;
    logic [15:0] data;
    bit          fd;
    bit          sync;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   exp_sync = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c, input int b, input int p);
    return 8'((r * 16 + c + b * 4 + p) & 255);
  endfunction

  function automatic logic [15:0] winMax(input int wr, input int wc, input int b);
    logic [15:0] res;
    logic [7:0]  m, v;
    res = '0;
    for (int p = 0; p < 2; p++) begin
      m = 8'd0;
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++) begin
          v = pix(2 * wr + dr, 2 * wc + dc, b, p);
          if (v > m) m = v;
        end
      res[p*8 +: 8] = m;
    end
    return res;
  endfunction

  function automatic exp_t idleExp(input bit zero, input bit sync);
    exp_t e;
    e.valid = 1'b0; e.zero = zero; e.grp = '0; e.col = '0; e.row = '0;
    e.data = '0; e.fd = 1'b0; e.sync = sync;
    return e;
  endfunction

  // Outputs seen at each falling edge belong to the step pushed one cycle earlier.
  task automatic monitorOutputs();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("out_valid", out_valid, e.valid);
      checkOutput("frame_done", frame_done, e.fd);
      checkOutput("sync_err", sync_err, e.sync);
      if (e.valid || e.zero) begin
        checkOutput("out_data", out_data, e.data);
        checkOutput("out_group", out_group, e.grp);
        checkOutput("out_col", out_col, e.col);
        checkOutput("out_row", out_row, e.row);
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input bit sof,
                               input logic [15:0] d, input exp_t e);
    @(negedge clk);
    monitorOutputs();
    res_n    = rst;
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
    sb.push_back(e);
  endtask

  task automatic idleSteps(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, idleExp(1'b0, exp_sync));
  endtask

  task automatic driveFrame(input int nbeats, input bit gaps, input bit sof_first, input bit sof_err);
    for (int i = 0; i < nbeats; i++) begin
      int b, c, r;
      exp_t e;
      b = i % 4;
      c = (i / 4) % 16;
      r = i / 64;
      if (i == 0 && sof_first && sof_err) exp_sync = 1'b1;
      e = idleExp(1'b0, exp_sync);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.valid = 1'b1;
        e.grp   = 2'(b);
        e.col   = 3'(c / 2);
        e.row   = 3'(r / 2);
        e.data  = winMax(r / 2, c / 2, b);
        e.fd    = (i == 1023);
      end
      applyStimulus(1'b0, 1'b1, sof_first && (i == 0), {pix(r, c, b, 1), pix(r, c, b, 0)}, e);
      if (gaps)
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hDEAD, idleExp(1'b0, exp_sync));
    end
  endtask

  task automatic sBeat(input logic [7:0] l0, input logic [7:0] l1);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = {l1, l0};
  endtask

  task automatic sWindow(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] c0, input logic [7:0] c1,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [15:0] expected);
    sBeat(a0, a1);
    sBeat(b0, b1);
    sBeat(c0, c1);
    @(negedge clk);
    checkOutput("s_valid_early", s_out_valid, 1'b0);
    s_data = {d1, d0};
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("s_out_valid", s_out_valid, 1'b1);
    checkOutput("s_out_data", s_out_data, expected);
    checkOutput("s_frame_done", s_frame_done, 1'b1);
    checkOutput("s_sync_err", s_sync_err, 1'b0);
    @(negedge clk);
    checkOutput("s_valid_pulse", s_out_valid, 1'b0);
  endtask

  initial begin
    res_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; pool_mode = 1'b0;
    s_res_n = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; s_pool_mode = 1'b0;

    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, idleExp(1'b1, 1'b0));

    $display("[TB] continuous frame");
    driveFrame(1024, 1'b0, 1'b1, 1'b0);
    idleSteps(3);

    $display("[TB] frame with valid gaps");
    driveFrame(1024, 1'b1, 1'b0, 1'b0);
    idleSteps(3);

    $display("[TB] misaligned start of frame");
    driveFrame(214, 1'b0, 1'b0, 1'b0);
    driveFrame(1024, 1'b0, 1'b1, 1'b1);
    idleSteps(3);

    $display("[TB] reset mid-frame");
    driveFrame(100, 1'b0, 1'b0, 1'b0);
    exp_sync = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h5555, idleExp(1'b1, 1'b0));
    driveFrame(1024, 1'b0, 1'b0, 1'b0);
    idleSteps(3);

    $display("[TB] signed max window");
    @(negedge clk);
    s_res_n = 1'b0;
    sWindow(8'hFB, 8'd3, 8'hFE, 8'd100, 8'h80, 8'hFF, 8'hF9, 8'd50, {8'd100, 8'hFE});

`ifdef POOL_AVG_EN
    $display("[TB] signed average windows");
    s_pool_mode = 1'b1;
    sWindow(8'd10, 8'd10, 8'd11, 8'd11, 8'd12, 8'd12, 8'd13, 8'd13, {8'd11, 8'd11});
    sWindow(8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFE, 8'hFE, {8'hFD, 8'hFD});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multichannel_pool_unit.md
Name: multichannel_pool_unit

Overview:
- Parametrised successor to the fixed 2x2 per-kernel pooling stage. Consumes the time-multiplexed convolution stream: each pixel arrives as CyclesPerPixel beats, each beat carrying ProcessingElements channel values.
- Performs non-overlapping PoolN x PoolN max pooling across all NumberOfK channels with one shared partial-result store, instead of one pooling instance per kernel.
- Adds frame resynchronisation, a sync-error flag and an optional average mode.
- Sits between convolution_stage output registers and the next layer's buffer.

Parameters:
- BitSize, 8, channel sample width.
- ImageWidth, 16, input pixels per row.
- ImageHeight, 16, input rows per frame.
- NumberOfK, 8, channel count.
- ProcessingElements, 2, channels per beat.
- PoolN, 2, window side and stride. ImageWidth and ImageHeight must be multiples of PoolN.
- Signed, 1, 1 = two's-complement compare/average, 0 = unsigned.
- Derived localparam CyclesPerPixel = NumberOfK/ProcessingElements. NumberOfK must be a multiple of ProcessingElements.

Ports:
- clk  in  1  clock, rising edge.
- res_n  in  1  reset, synchronous, active-high (despite the name).
- in_valid  in  1  beat valid.
- in_sof  in  1  start-of-frame marker, sampled only with in_valid.
- in_data  in  [ProcessingElements-1:0][BitSize-1:0]  beat channel values.
- out_valid  out  1  pooled beat valid.
- out_group  out  clog2(CyclesPerPixel) (min 1)  channel group index; lane p = channel out_group*ProcessingElements+p.
- out_col  out  clog2(ImageWidth/PoolN) (min 1)  pooled column.
- out_row  out  clog2(ImageHeight/PoolN) (min 1)  pooled row.
- out_data  out  [ProcessingElements-1:0][BitSize-1:0]  pooled values.
- frame_done  out  1  one-cycle pulse with the last pooled beat of a frame.
- sync_err  out  1  sticky misalignment flag.

Behaviour:
- Counters beat (0..CPP-1), col (0..W-1), row (0..H-1). All advance only on in_valid, beat fastest. All wrap to 0 after (H-1, W-1, CPP-1); the next frame follows with no dead cycle.
- Gaps in in_valid are allowed; all state is held.
- Store pm[W/PoolN][NumberOfK] of BitSize. Indexed by wc = col/PoolN and channel = beat*PE + p.
- Window-first element (row%PoolN==0 and col%PoolN==0): pm <= in_data.
- Otherwise: pm <= max(pm, in_data), with the compare signed or unsigned per Signed.
- Window-last element (row%PoolN==PoolN-1 and col%PoolN==PoolN-1): the next cycle must show:
  - out_valid=1
  - out_data = max(pm, in_data)
  - out_group=beat, out_col=wc, out_row=row/PoolN
- Latency is exactly 1 cycle from the last contributing beat. out_valid is low otherwise. There is no backpressure.
- frame_done=1 in the same cycle as out_valid for the input beat (H-1, W-1, CPP-1).
- in_sof handling:
  - in_sof=1 with in_valid=1: the beat is treated as position (0,0,0) and counters continue from there.
  - If the counters were not already at (0,0,0), the partial windows are discarded and sync_err <= 1.
  - sync_err stays set until reset.
  - in_sof without in_valid is ignored.
- Reset:
  - Counters, out_valid, out_group, out_col, out_row, out_data, frame_done and sync_err all go to 0.
  - pm is not reset; the window-first overwrite makes this safe.
  - Reset mid-frame discards all partial windows. The next valid beat is (0,0,0).
  - Reset has priority over in_valid in the same cycle.
- PoolN=1 degenerates to a registered pass-through with output coordinates.

Optional Feature:
- Macro POOL_AVG_EN. When defined:
  - Adds input port pool_mode (1 bit), sampled only on beat (0,0,0) of a frame and held for the whole frame.
  - pool_mode=1 selects average: pm widens to BitSize+2*clog2(PoolN) and accumulates sums. Output = sum >>> clog2(PoolN*PoolN), arithmetic shift if Signed, truncated to BitSize. PoolN must be a power of two.
  - pool_mode=0 selects max exactly as above.
- When undefined: no pool_mode port, pm is BitSize wide, max only.

Test Plan:
- Defaults, unsigned frame with in_data lane p = (row*16+col+beat*4+p)&0xFF, continuous valid -> 256 out_valid beats. First output (row0, col0, group0) = {lane1=18, lane0=17}. frame_done coincides with the out_valid for out_row=7, out_col=7, out_group=3.
- Signed=1, one window with channel 0 values -5, -2, -128, -7 -> out_data lane0 = 0xFE (-2), exactly 1 cycle after the 4th contributing beat.
- Same frame with in_valid toggled 1/0 every cycle -> identical outputs and order, each out_valid 1 cycle after its source beat.
- in_sof asserted at input position (row 3, col 5, beat 2), then a clean frame -> sync_err=1 and stays 1. The following 256 outputs match scenario 1.
- res_n=1 for one cycle mid-frame, then a full frame -> all outputs 0 during reset. The next frame's results match scenario 1 exactly.
- POOL_AVG_EN defined, pool_mode=1, Signed=1, window values 10, 11, 12, 13 -> out_data 11. Values -3, -3, -3, -2 -> -3 (0xFD).
